// File: rtl/usr_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : usr_deser_if
//  Description : Serial-in / parallel-out bundle for usr_deser. The slave
//                modport is the deserializer's view; the master modport is
//                the view of whatever drives the serial line and consumes
//                the parallel words.
//  Revision    : 1.0 - initial release
// ============================================================================
interface usr_deser_if #(
    parameter int WIDTH = 4
) ();
    logic             sin;
    logic             sin_en;
    logic             pready;
    logic [WIDTH-1:0] pout;
    logic             pvalid;
    logic             busy;
    logic             frm_err;
    logic             par_err;
    logic             ovr_err;

    modport slave (
        input  sin, sin_en, pready,
        output pout, pvalid, busy, frm_err, par_err, ovr_err
    );

    modport master (
        output sin, sin_en, pready,
        input  pout, pvalid, busy, frm_err, par_err, ovr_err
    );
endinterface
`default_nettype wire

// File: rtl/usr_deser.sv
`default_nettype none
// ============================================================================
//  Module      : usr_deser
//  Description : Serial-frame deserializer. Frame = start(0), WIDTH data bits
//                MSB first, optional even parity, stop(1). Good words land in
//                a one-entry valid/ready holding register; bad words raise
//                single-cycle error pulses.
//                Optional feature macro: USR_DESER_PARITY_EN (adds the parity
//                bit to the frame and makes par_err functional).
//  Revision    : 1.0 - initial release
// ============================================================================
module usr_deser #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,   // asynchronous, active low
    usr_deser_if.slave   bus
);

    localparam int                c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  r_pout;
    logic              r_pvalid;
    logic              r_frm_err;
    logic              r_ovr_err;
`ifdef USR_DESER_PARITY_EN
    logic              r_par;
    logic              r_par_err;
`endif

    logic              w_par_ok;
    logic              w_load;
    logic              w_pop;

    // Even parity over data plus parity bit; always good when parity is absent.
`ifdef USR_DESER_PARITY_EN
    assign w_par_ok = ~(^{r_shift, r_par});
`else
    assign w_par_ok = 1'b1;
`endif

    // A word is delivered on the stop strobe only when stop=1 and parity holds.
    assign w_load = bus.sin_en && (r_state == S_STOP) && bus.sin && w_par_ok;
    assign w_pop  = r_pvalid && bus.pready;

    // Frame sequencer, shift register, holding register and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_pout    <= '0;
            r_pvalid  <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr_err <= 1'b0;
`ifdef USR_DESER_PARITY_EN
            r_par     <= 1'b0;
            r_par_err <= 1'b0;
`endif
        end else begin
            r_frm_err <= 1'b0;
            r_ovr_err <= 1'b0;
`ifdef USR_DESER_PARITY_EN
            r_par_err <= 1'b0;
`endif
            if (bus.sin_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!bus.sin) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {r_shift[WIDTH-2:0], bus.sin};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
`ifdef USR_DESER_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
`ifdef USR_DESER_PARITY_EN
                    S_PARITY: begin
                        r_par   <= bus.sin;
                        r_state <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        r_state   <= S_IDLE;
                        r_frm_err <= ~bus.sin;
`ifdef USR_DESER_PARITY_EN
                        r_par_err <= ~w_par_ok;
`endif
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            // A full, unread holding register wins over a new word.
            if (w_load) begin
                if (r_pvalid && !bus.pready) begin
                    r_ovr_err <= 1'b1;
                end else begin
                    r_pout   <= r_shift;
                    r_pvalid <= 1'b1;
                end
            end else if (w_pop) begin
                r_pvalid <= 1'b0;
            end
        end
    end

    assign bus.pout    = r_pout;
    assign bus.pvalid  = r_pvalid;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.frm_err = r_frm_err;
    assign bus.ovr_err = r_ovr_err;
`ifdef USR_DESER_PARITY_EN
    assign bus.par_err = r_par_err;
`else
    assign bus.par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/usr_deser.md
# usr_deser

Serial-frame deserializer that consumes the bit stream produced by the universal shift register's serial output (`sout`) and rebuilds parallel words. It detects a start bit, shifts in `WIDTH` data bits MSB-first (matching the left-shift direction), optionally checks even parity, validates the stop bit, and presents each good word through a one-entry valid/ready holding register. It sits directly downstream of the shift register on the serial link and feeds parallel consumers.

## Interface
- `WIDTH`, 4, data bits per frame (2..16)
- `clk` input 1 — single clock, all state on rising edge
- `rst` input 1 — asynchronous, active-low reset
- `sin` input 1 — serial line; idle level 1
- `sin_en` input 1 — bit strobe; `sin` sampled only in cycles with `sin_en`=1
- `pready` input 1 — consumer accepts `pout` when `pvalid`&&`pready`
- `pout` output WIDTH — received word (first received bit at `pout[WIDTH-1]`)
- `pvalid` output 1 — holding register full
- `busy` output 1 — frame in progress (state ≠ IDLE)
- `frm_err` output 1 — one-cycle pulse: stop bit sampled as 0
- `par_err` output 1 — one-cycle pulse: parity mismatch (parity build only)
- `ovr_err` output 1 — one-cycle pulse: good word dropped, holding register full

## Operation
- Frame on the line: start(0), D[WIDTH-1]..D[0], [parity], stop(1).
- States: IDLE → DATA → (PARITY) → STOP → IDLE.
- IDLE: on `sin_en`&&`sin`=0 → DATA, bit counter cleared. `sin`=1 strobes ignored. No false-start filtering.
- DATA: each strobe shifts `sin` into LSB of shift reg, counter++; after WIDTH-th bit → PARITY (or STOP when parity compiled out).
- PARITY: strobe captures parity bit → STOP. Check is even: XOR of data bits and parity bit must be 0.
- STOP: strobe samples stop bit, always → IDLE. Word is good iff stop=1 and parity ok.
- Good word: loads holding register, `pvalid`←1. If `pvalid`=1 and `pready`=0 that cycle, word dropped, `ovr_err` pulses, old word kept. If `pvalid`=1 and `pready`=1 same cycle, old word consumed and new word loaded (`pvalid` stays 1).
- Bad word: discarded, holding register untouched; `frm_err` and/or `par_err` pulse (both if both fail). Bad word never sets `ovr_err`.
- Pop: `pvalid`&&`pready` with no load → `pvalid`←0; `pout` holds last value.
- Counter width `$clog2(WIDTH+1)`; never wraps beyond WIDTH.

## Timing
- Reset (rst=0, any time incl. mid-frame): state IDLE, counter 0, shift reg 0, `pout`=0, `pvalid`=0, `busy`=0, all error pulses 0. Partial frame lost.
- Latency: `pvalid`/error pulses assert in the cycle after the stop-bit strobe edge (registered).
- `busy` rises the cycle after start-bit strobe, falls the cycle after stop-bit strobe.
- Cycles without `sin_en` freeze state, counter, shift reg; handshake on `pready` still operates.
- Errors are single-cycle pulses, never sticky.
- Back-to-back frames: a start bit may be accepted on the strobe immediately after the stop strobe.

## Configuration
- `USR_DESER_PARITY_EN` defined: PARITY state present, frame is WIDTH+3 bits, `par_err` functional.
- Not defined: PARITY state removed, frame is WIDTH+2 bits, `par_err` tied 0.

## Test plan
- Reset: drive rst=0 mid-frame after 2 data bits -> all outputs 0, next full frame 0,1,0,1,1,1,1 (parity build, WIDTH=4) received as `pout`=4'b1011, `pvalid`=1.
- Good frame with `pready`=1 held: strobes 0,0,1,1,0,0,1 -> `pout`=4'b0110 one cycle after stop strobe, popped next cycle, `pvalid` back to 0.
- Framing error: 0,1,1,1,1,0,0 -> `frm_err` one-cycle pulse, `pvalid` stays 0; parity error 0,1,0,0,0,0,1 -> `par_err` pulse only.
- Overrun: two good frames 4'hA then 4'h5 with `pready`=0 -> `pout`=4'hA kept, `ovr_err` pulses once; repeat with `pready`=1 at second load -> `pout`=4'h5, no `ovr_err`.
- Sparse strobes: same frame as case 2 with `sin_en` high 1 cycle in 3 and random `sin` in off-cycles -> identical `pout`=4'b0110.
- Parity compiled out: frame 0,1,1,0,1,1 -> `pout`=4'b1101, `par_err` never asserts.
